// File: rtl/mips_alu_mdu_if.sv
// Request/response bus of the MIPS execute unit: operands in, result and flags out,
// each direction with its own valid/ready handshake.
interface mips_alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic [3:0]       ALUCtrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output in_valid, srcA, srcB, ALUCtrl, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, srcA, srcB, ALUCtrl, out_ready,
        output in_ready, out_valid, ALUResult, Zero, overflow, div_by_zero
    );
endinterface

// File: rtl/mips_alu_mdu.sv
// MIPS EX-stage unit: single-cycle ALU plus an iterative multiply/divide unit owning HI/LO.
// Multi-cycle ops stall the requester through the in_ready/out_valid handshake.
module mips_alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic           clk,
    input logic           rst,
    mips_alu_mdu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic             dbz_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic             is_mul;
    logic             neg_q;
    logic             neg_r;
    logic             dbz_pend;
    logic [WIDTH-1:0] a_save;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [SHW-1:0]   count;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign a    = bus.srcA;
    assign b    = bus.srcB;
    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.ALUCtrl)
            4'b0000: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0001: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0010: alu_res = a & b;
            4'b0011: alu_res = a | b;
            4'b0100: alu_res = a << b[SHW-1:0];
            4'b0101: alu_res = a >> b[SHW-1:0];
            4'b0110: alu_res = WIDTH'($signed(a) < $signed(b));
            4'b0111: alu_res = WIDTH'(a < b);
            4'b1000: alu_res = a ^ b;
            4'b1001: alu_res = ~(a | b);
            4'b1010: alu_res = hi;
            4'b1011: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // Signed MDU ops (mult, div) have ALUCtrl[0] clear; iterate on magnitudes.
    logic             req_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign req_signed = ~bus.ALUCtrl[0];
    assign a_mag      = (req_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag      = (req_signed && b[WIDTH-1]) ? -b : b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [WIDTH-1:0]   r_nx;
    logic [WIDTH-1:0]   q_nx;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    // One iteration: multiply shifts {r,q} right, divide shifts the dividend left into r.
    always_comb begin
        mul_sum   = {1'b0, r} + (q[0] ? {1'b0, m} : '0);
        div_trial = {r, q[WIDTH-1]};
        div_ge    = div_trial >= {1'b0, m};
        div_sub   = div_trial[WIDTH-1:0] - m;
        if (is_mul) begin
            r_nx = mul_sum[WIDTH:1];
            q_nx = {mul_sum[0], q[WIDTH-1:1]};
        end else begin
            r_nx = div_ge ? div_sub : div_trial[WIDTH-1:0];
            q_nx = {q[WIDTH-2:0], div_ge};
        end
        prod   = neg_q ? -{r_nx, q_nx} : {r_nx, q_nx};
        fin_hi = '0;
        fin_lo = '0;
        if (is_mul) begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end else if (dbz_pend) begin
            fin_hi = a_save;
            fin_lo = '1;
        end else begin
            fin_hi = neg_r ? -r_nx : r_nx;
            fin_lo = neg_q ? -q_nx : q_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            is_mul      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz_pend    <= 1'b0;
            a_save      <= '0;
            m           <= '0;
            r           <= '0;
            q           <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        if (bus.ALUCtrl[3:2] == 2'b11) begin
                            is_mul   <= ~bus.ALUCtrl[1];
                            neg_q    <= req_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r    <= req_signed && a[WIDTH-1];
                            dbz_pend <= bus.ALUCtrl[1] && (b == '0);
                            a_save   <= a;
                            m        <= bus.ALUCtrl[1] ? b_mag : a_mag;
                            q        <= bus.ALUCtrl[1] ? a_mag : b_mag;
                            r        <= '0;
                            count    <= '0;
                            state    <= BUSY;
                        end else begin
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            ovf_q       <= alu_ovf;
                            dbz_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                BUSY: begin
                    r     <= r_nx;
                    q     <= q_nx;
                    count <= count + 1'b1;
                    if (count == SHW'(WIDTH - 1)) begin
                        hi          <= fin_hi;
                        lo          <= fin_lo;
                        result_q    <= fin_lo;
                        zero_q      <= (fin_lo == '0);
                        ovf_q       <= 1'b0;
                        dbz_q       <= dbz_pend;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.ALUResult   = result_q;
    assign bus.Zero        = zero_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mips_alu_mdu.sv
// Directed-vector bench for mips_alu_mdu with hand-computed expected results.
module tb_mips_alu_mdu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int mismatched = 0;

    mips_alu_mdu_if #(.WIDTH(32)) bus ();

    mips_alu_mdu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE, wait for out_valid, capture, then retire it.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic ovf, output logic z,
                                 output logic dz, output int lat);
        bus.ALUCtrl   = op;
        bus.srcA      = a;
        bus.srcB      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = bus.ALUResult;
        ovf = bus.overflow;
        z   = bus.Zero;
        dz  = bus.div_by_zero;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    logic [31:0] res;
    logic ovf, z, dz;
    int lat;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.srcA      = '0;
        bus.srcB      = '0;
        bus.ALUCtrl   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset ALUResult", 64'(bus.ALUResult), 64'd0);
        checkOutput("reset flags", 64'({bus.Zero, bus.overflow, bus.div_by_zero}), 64'd0);

        applyStimulus(4'b0000, 32'h7FFFFFFF, 32'h00000001, res, ovf, z, dz, lat);
        checkOutput("add latency", 64'(lat), 64'd1);
        checkOutput("add result", 64'(res), 64'h80000000);
        checkOutput("add ovf/zero", 64'({ovf, z}), 64'b10);
        checkOutput("in_ready after retire", 64'(bus.in_ready), 64'd1);

        applyStimulus(4'b0001, 32'd5, 32'd5, res, ovf, z, dz, lat);
        checkOutput("sub result", 64'(res), 64'd0);
        checkOutput("sub ovf/zero", 64'({ovf, z}), 64'b01);
        applyStimulus(4'b0001, 32'h80000000, 32'd1, res, ovf, z, dz, lat);
        checkOutput("sub ovf result", 64'(res), 64'h7FFFFFFF);
        checkOutput("sub ovf flag", 64'(ovf), 64'd1);

        applyStimulus(4'b0100, 32'h00000001, 32'hFFFFFFE4, res, ovf, z, dz, lat);
        checkOutput("sll", 64'(res), 64'h00000010);
        applyStimulus(4'b0101, 32'h80000000, 32'd31, res, ovf, z, dz, lat);
        checkOutput("srl", 64'(res), 64'h00000001);
        applyStimulus(4'b0110, 32'hFFFFFFFF, 32'd1, res, ovf, z, dz, lat);
        checkOutput("slt", 64'(res), 64'd1);
        applyStimulus(4'b0111, 32'hFFFFFFFF, 32'd1, res, ovf, z, dz, lat);
        checkOutput("sltu", 64'(res), 64'd0);
        checkOutput("sltu zero", 64'(z), 64'd1);
        applyStimulus(4'b0010, 32'h0000F0F0, 32'h0000FF00, res, ovf, z, dz, lat);
        checkOutput("and", 64'(res), 64'h0000F000);
        applyStimulus(4'b0011, 32'h0000F0F0, 32'h0000FF00, res, ovf, z, dz, lat);
        checkOutput("or", 64'(res), 64'h0000FFF0);
        applyStimulus(4'b1000, 32'h0000F0F0, 32'h0000FF00, res, ovf, z, dz, lat);
        checkOutput("xor", 64'(res), 64'h00000FF0);
        applyStimulus(4'b1001, 32'd0, 32'd0, res, ovf, z, dz, lat);
        checkOutput("nor", 64'(res), 64'hFFFFFFFF);

        applyStimulus(4'b1100, 32'hFFFFFFFE, 32'd3, res, ovf, z, dz, lat);
        checkOutput("mult latency", 64'(lat), 64'd33);
        checkOutput("mult LO", 64'(res), 64'hFFFFFFFA);
        applyStimulus(4'b1010, 32'd0, 32'd0, res, ovf, z, dz, lat);
        checkOutput("mult HI", 64'(res), 64'hFFFFFFFF);
        applyStimulus(4'b1101, 32'hFFFFFFFE, 32'd3, res, ovf, z, dz, lat);
        checkOutput("multu LO", 64'(res), 64'hFFFFFFFA);
        applyStimulus(4'b1010, 32'd0, 32'd0, res, ovf, z, dz, lat);
        checkOutput("multu HI", 64'(res), 64'h00000002);
        applyStimulus(4'b1011, 32'd0, 32'd0, res, ovf, z, dz, lat);
        checkOutput("mflo", 64'(res), 64'hFFFFFFFA);

        applyStimulus(4'b1110, 32'hFFFFFFF9, 32'd2, res, ovf, z, dz, lat);
        checkOutput("div LO", 64'(res), 64'hFFFFFFFD);
        checkOutput("div latency", 64'(lat), 64'd33);
        applyStimulus(4'b1010, 32'd0, 32'd0, res, ovf, z, dz, lat);
        checkOutput("div HI", 64'(res), 64'hFFFFFFFF);
        applyStimulus(4'b1111, 32'd7, 32'd0, res, ovf, z, dz, lat);
        checkOutput("divu/0 LO", 64'(res), 64'hFFFFFFFF);
        checkOutput("divu/0 flag", 64'(dz), 64'd1);
        applyStimulus(4'b1010, 32'd0, 32'd0, res, ovf, z, dz, lat);
        checkOutput("divu/0 HI", 64'(res), 64'd7);
        checkOutput("dbz clears", 64'(dz), 64'd0);
        applyStimulus(4'b1110, 32'h80000000, 32'hFFFFFFFF, res, ovf, z, dz, lat);
        checkOutput("div min/-1 LO", 64'(res), 64'h80000000);
        checkOutput("div min/-1 flags", 64'({ovf, dz}), 64'd0);
        applyStimulus(4'b1010, 32'd0, 32'd0, res, ovf, z, dz, lat);
        checkOutput("div min/-1 HI", 64'(res), 64'd0);

        bus.ALUCtrl  = 4'b0000;
        bus.srcA     = 32'd3;
        bus.srcB     = 32'd4;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("bp out_valid", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i == 2);
            bus.ALUCtrl  = 4'b0001;
            bus.srcA     = 32'd9;
            bus.srcB     = 32'd1;
            @(negedge clk);
            checkOutput("bp hold result", 64'(bus.ALUResult), 64'd7);
            checkOutput("bp hold state", 64'({bus.in_ready, bus.out_valid, bus.Zero, bus.overflow}), 64'b0100);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("bp release", 64'({bus.in_ready, bus.out_valid}), 64'b10);
        @(negedge clk);
        checkOutput("bp no stray accept", 64'({bus.in_ready, bus.out_valid, bus.ALUResult}), {32'd0, 2'b10, 32'd7});

        applyStimulus(4'b1100, 32'hFFFFFFFE, 32'd3, res, ovf, z, dz, lat);
        bus.ALUCtrl  = 4'b1110;
        bus.srcA     = 32'd100;
        bus.srcB     = 32'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid-op reset", 64'({bus.in_ready, bus.out_valid}), 64'b10);
        checkOutput("mid-op reset result", 64'(bus.ALUResult), 64'd0);
        applyStimulus(4'b1010, 32'd0, 32'd0, res, ovf, z, dz, lat);
        checkOutput("reset HI", 64'(res), 64'd0);
        applyStimulus(4'b1011, 32'd0, 32'd0, res, ovf, z, dz, lat);
        checkOutput("reset LO", 64'(res), 64'd0);
        checkOutput("reset LO zero", 64'(z), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mips_alu_mdu.md
Name: mips_alu_mdu

Overview:
- Next-generation MIPS execute unit with a parametrised datapath width.
- Combines the single-cycle ALU operations with an iterative multiply/divide unit that owns the architectural HI/LO registers.
- Sits in the EX stage and uses a valid/ready handshake, so the pipeline stalls while a multi-cycle operation runs.
- Flags (zero, signed overflow, divide-by-zero) are registered and returned with every result.

Parameters:
WIDTH, 32, operand/result width in bits; must be even and at least 8.
SHW, $clog2(WIDTH), shift-amount width; the shift amount is taken from srcB[SHW-1:0].

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request this cycle
srcA  input  WIDTH  operand A (rs)
srcB  input  WIDTH  operand B (rt or immediate/shamt)
ALUCtrl  input  4  operation select
out_valid  output  1  result and flags are valid
out_ready  input  1  consumer accepts the result
ALUResult  output  WIDTH  registered result
Zero  output  1  ALUResult == 0
overflow  output  1  signed overflow (add/sub only)
div_by_zero  output  1  div/divu issued with srcB == 0

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state IDLE, in_ready=1, out_valid=0, ALUResult=0, Zero=0, overflow=0, div_by_zero=0, HI=0, LO=0.
- Reset mid-operation abandons the operation; HI/LO are not updated by it and no result is produced.
- Opcodes:
  - 0000 add, 0001 sub, 0010 and, 0011 or.
  - 0100 sll, 0101 srl (logical), 0110 slt (signed), 0111 sltu.
  - 1000 xor, 1001 nor.
  - 1010 mfhi, 1011 mflo.
  - 1100 mult, 1101 multu, 1110 div, 1111 divu.
- Accept rule: a request is accepted when in_valid && in_ready. in_ready = 1 only in IDLE. Operands and opcode are captured at acceptance.
- State IDLE:
  - On accept of opcodes 0000-1011, the result is computed and the unit goes to DONE next cycle (latency 1).
  - On accept of 1100-1111, the unit goes to BUSY.
- State BUSY:
  - Radix-2 shift-add multiplier or restoring divider; iteration counter runs WIDTH cycles.
  - Signed ops work on magnitudes and fix the sign at the end.
  - On the final cycle HI/LO are written and the unit goes to DONE. Accept-to-out_valid latency is WIDTH+1 cycles.
- State DONE:
  - out_valid=1; ALUResult and flags are held stable until out_valid && out_ready, then the unit returns to IDLE.
  - No new request is accepted in the same cycle (in_ready=0 in DONE).
- Results:
  - sll/srl use srcB[SHW-1:0]; upper srcB bits are ignored.
  - slt/sltu produce 1 or 0, zero-extended.
  - mult/multu: {HI,LO} = full 2*WIDTH product; ALUResult = LO.
  - div/divu: LO = quotient (truncated toward zero), HI = remainder (sign follows the dividend); ALUResult = LO.
  - Signed div of MIN by -1: LO = MIN, HI = 0; no flag raised.
  - Divide by zero: HI = srcA, LO = all ones, div_by_zero = 1.
  - mfhi/mflo return the current HI/LO; HI/LO are unchanged.
- Flags:
  - overflow = signed overflow for add/sub; 0 for all other ops. No trap is raised.
  - Zero = (ALUResult == 0) for every op.
  - div_by_zero = 0 except for a div/divu by zero.
- HI/LO are only written by mult/multu/div/divu completion.
- in_valid asserted while in BUSY/DONE is ignored; the requester must hold it.
- Outputs never glitch while out_valid=1 and out_ready=0.

Test Plan:
1. Reset then add 0x7FFFFFFF+0x00000001 -> out_valid 1 cycle after accept; ALUResult 0x80000000, overflow=1, Zero=0. Then sub 5-5 -> ALUResult 0, Zero=1, overflow=0.
2. sll 0x00000001 by srcB 0xFFFFFFE4 (shamt 4) -> 0x00000010. slt 0xFFFFFFFF,1 -> 1; sltu with the same operands -> 0.
3. mult 0xFFFFFFFE (-2) x 0x00000003 -> out_valid exactly 33 cycles after accept; ALUResult 0xFFFFFFFA. A following mfhi returns 0xFFFFFFFF; multu with the same operands gives HI 0x00000002, LO 0xFFFFFFFA.
4. div -7/2 -> LO 0xFFFFFFFD (-3), HI 0xFFFFFFFF (-1). divu 7/0 -> div_by_zero=1, LO 0xFFFFFFFF, HI 7. div 0x80000000/-1 -> LO 0x80000000, HI 0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> ALUResult/flags stable, in_ready=0, and an in_valid pulse during this time is not accepted. Raise out_ready -> IDLE next cycle.
6. Assert rst at cycle 10 of a div -> next cycle in_ready=1, out_valid=0; mfhi/mflo then return 0.
